// File: rtl/inst_rom_arb.sv
// Two-port (CPU / debug) arbiter in front of a combinational instruction ROM.
// Define INST_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed CPU priority.
module inst_rom_arb #(
    parameter int ROM_DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_inst,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_inst,
    output logic        dbg_err,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        busy
);

`ifdef INST_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        DBG_RD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        lastCpu_q, lastCpu_d;
    logic        cpuAck_q, cpuErr_q, dbgAck_q, dbgErr_q;
    logic [31:0] cpuInst_q, dbgInst_q;
    logic        cpuElig, dbgElig, cpuWins;
    logic        inRange;
    logic [31:0] readData;

    assign inRange  = (addr_q[31:ROM_DEPTH_LOG2+2] == '0);
    assign readData = inRange ? rom_inst : 32'h0;

    // The port being read this cycle sits out the next arbitration, which
    // caps a single port at one access per two cycles.
    always_comb begin
        state_d   = IDLE;
        addr_d    = addr_q;
        lastCpu_d = lastCpu_q;
        cpuElig   = cpu_req && (state_q != CPU_RD);
        dbgElig   = dbg_req && (state_q != DBG_RD);
        cpuWins   = cpuElig && (!dbgElig || !RR_EN || !lastCpu_q);
        if (cpuWins) begin
            state_d   = CPU_RD;
            addr_d    = cpu_addr;
            lastCpu_d = 1'b1;
        end else if (dbgElig) begin
            state_d   = DBG_RD;
            addr_d    = dbg_addr;
            lastCpu_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            lastCpu_q <= 1'b0;
            cpuAck_q  <= 1'b0;
            cpuErr_q  <= 1'b0;
            cpuInst_q <= 32'h0;
            dbgAck_q  <= 1'b0;
            dbgErr_q  <= 1'b0;
            dbgInst_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lastCpu_q <= lastCpu_d;
            cpuAck_q  <= (state_q == CPU_RD);
            cpuErr_q  <= (state_q == CPU_RD) && !inRange;
            dbgAck_q  <= (state_q == DBG_RD);
            dbgErr_q  <= (state_q == DBG_RD) && !inRange;
            if (state_q == CPU_RD) begin
                cpuInst_q <= readData;
            end
            if (state_q == DBG_RD) begin
                dbgInst_q <= readData;
            end
        end
    end

    assign cpu_ack   = cpuAck_q;
    assign cpu_err   = cpuErr_q;
    assign cpu_inst  = cpuInst_q;
    assign dbg_ack   = dbgAck_q;
    assign dbg_err   = dbgErr_q;
    assign dbg_inst  = dbgInst_q;
    assign cpu_stall = rst_n && cpu_req && !cpuAck_q;
    assign busy      = (state_q != IDLE);
    assign rom_en    = (state_q != IDLE) && inRange;
    assign rom_addr  = addr_q & 32'hFFFF_FFFC;

endmodule

// File: tb/tb_inst_rom_arb.sv
// Self-checking bench for inst_rom_arb: directed vector table, hand-written
// contention/reset sequences, then randomized traffic against a reference model.
module tb_inst_rom_arb;

    localparam int D     = 10;
    localparam int WORDS = 1 << D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, dbg_req;
    logic [31:0] cpu_addr, dbg_addr;
    logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, rom_en, busy;
    logic [31:0] cpu_inst, dbg_inst, rom_addr, rom_inst;
    logic [31:0] romMem [0:WORDS-1];

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    assign rom_inst = romMem[rom_addr[D+1:2]];

    inst_rom_arb #(.ROM_DEPTH_LOG2(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .cpu_inst(cpu_inst), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_inst(dbg_inst), .dbg_err(dbg_err),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .busy(busy)
    );

    typedef struct {
        logic        cpuReq;
        logic [31:0] cpuAddr;
        logic        dbgReq;
        logic [31:0] dbgAddr;
        logic        cpuAck;
        logic [31:0] cpuInst;
        logic        cpuErr;
        logic        dbgAck;
        logic [31:0] dbgInst;
        logic        dbgErr;
        logic        romEn;
        logic [31:0] romAddr;
        logic        busy;
        logic        stall;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cReq, input logic [31:0] cAddr,
                                 input logic dReq, input logic [31:0] dAddr);
        cpu_req  = cReq;
        cpu_addr = cAddr;
        dbg_req  = dReq;
        dbg_addr = dAddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic bit outOfRange(input logic [31:0] a);
        return (a >> (D + 2)) != 0;
    endfunction

    function automatic logic [31:0] expectedWord(input logic [31:0] a);
        if (outOfRange(a)) return 32'h0;
        return romMem[(a / 4) % WORDS];
    endfunction

    // Reference model state: which port (-1 none, 0 CPU, 1 debug) is reading
    // this cycle, who was granted last, and what each requester is doing.
    int          servingPort;
    int          lastGrant;
    logic [31:0] latchedAddr;
    logic        mReq  [2];
    logic [31:0] mAddr [2];
    logic        expAck [2];
    logic        expErr [2];
    logic [31:0] expInst [2];

    function automatic logic [31:0] randomAddr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'($urandom_range(0, WORDS * 4 - 1));
    endfunction

    initial begin
        bit cpuFirst;
        int winner;
        bit elig [2];

        for (int i = 0; i < WORDS; i++) romMem[i] = 32'h9E37_79B9 * 32'(i) + 32'h0123_4567;
        romMem[2] = 32'h2401_0001;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset cpu_ack", cpu_ack, 0);
        checkOutput("reset cpu_inst", cpu_inst, 0);
        checkOutput("reset cpu_err", cpu_err, 0);
        checkOutput("reset dbg_ack", dbg_ack, 0);
        checkOutput("reset dbg_inst", dbg_inst, 0);
        checkOutput("reset rom_en", rom_en, 0);
        checkOutput("reset rom_addr", rom_addr, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cpu_stall", cpu_stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read, out-of-range debug read, misaligned CPU read.
        vecs[0] = '{1'b1, 32'h8, 1'b0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h8, 1, 1};
        vecs[1] = '{1'b1, 32'h8, 1'b0, 32'h0, 1, 32'h2401_0001, 0, 0, 32'h0, 0, 0, 32'h8, 0, 0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h1000, 0, 32'h2401_0001, 0, 0, 32'h0, 0, 0, 32'h1000, 1, 0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h1000, 0, 32'h2401_0001, 0, 1, 32'h0, 1, 0, 32'h1000, 0, 0};
        vecs[4] = '{1'b1, 32'h6, 1'b0, 32'h0, 0, 32'h2401_0001, 0, 0, 32'h0, 0, 1, 32'h4, 1, 1};
        vecs[5] = '{1'b1, 32'h6, 1'b0, 32'h0, 1, romMem[1], 0, 0, 32'h0, 0, 0, 32'h4, 0, 0};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, romMem[1], 0, 0, 32'h0, 0, 0, 32'h4, 0, 0};

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].cpuReq, vecs[v].cpuAddr, vecs[v].dbgReq, vecs[v].dbgAddr);
            tick();
            checkOutput($sformatf("vec%0d cpu_ack", v), cpu_ack, vecs[v].cpuAck);
            checkOutput($sformatf("vec%0d cpu_inst", v), cpu_inst, vecs[v].cpuInst);
            checkOutput($sformatf("vec%0d cpu_err", v), cpu_err, vecs[v].cpuErr);
            checkOutput($sformatf("vec%0d dbg_ack", v), dbg_ack, vecs[v].dbgAck);
            checkOutput($sformatf("vec%0d dbg_inst", v), dbg_inst, vecs[v].dbgInst);
            checkOutput($sformatf("vec%0d dbg_err", v), dbg_err, vecs[v].dbgErr);
            checkOutput($sformatf("vec%0d rom_en", v), rom_en, vecs[v].romEn);
            checkOutput($sformatf("vec%0d rom_addr", v), rom_addr, vecs[v].romAddr);
            checkOutput($sformatf("vec%0d busy", v), busy, vecs[v].busy);
            checkOutput($sformatf("vec%0d cpu_stall", v), cpu_stall, vecs[v].stall);
        end

        // Simultaneous one-shot requests; last grant so far went to the CPU.
`ifdef INST_ARB_ROUND_ROBIN_EN
        cpuFirst = 1'b0;
`else
        cpuFirst = 1'b1;
`endif
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h14);
        tick();
        checkOutput("contend first rom_addr", rom_addr, cpuFirst ? 32'h10 : 32'h14);
        tick();
        checkOutput("contend first cpu_ack", cpu_ack, cpuFirst);
        checkOutput("contend first dbg_ack", dbg_ack, !cpuFirst);
        if (cpuFirst) cpu_req = 1'b0;
        else dbg_req = 1'b0;
        tick();
        checkOutput("contend second cpu_ack", cpu_ack, !cpuFirst);
        checkOutput("contend second dbg_ack", dbg_ack, cpuFirst);
        checkOutput("contend cpu_inst", cpu_inst, romMem[4]);
        checkOutput("contend dbg_inst", dbg_inst, romMem[5]);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("contend drained busy", busy, 0);

        // Reset asserted in the middle of a CPU read.
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0);
        tick();
        checkOutput("midreset busy before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset rom_en", rom_en, 0);
        checkOutput("midreset cpu_inst", cpu_inst, 0);
        checkOutput("midreset rom_addr", rom_addr, 0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("postreset cpu_ack", cpu_ack, 0);
        end
        applyStimulus(1'b1, 32'hC, 1'b0, 32'h0);
        tick();
        checkOutput("postreset req cpu_ack early", cpu_ack, 0);
        tick();
        checkOutput("postreset req cpu_ack", cpu_ack, 1);
        checkOutput("postreset req cpu_inst", cpu_inst, romMem[3]);
        cpu_req = 1'b0;
        tick();

        // Both ports held: strict alternation starting with the CPU.
        doReset();
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h4);
        tick();
        checkOutput("alt first no cpu_ack", cpu_ack, 0);
        checkOutput("alt first no dbg_ack", dbg_ack, 0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("alt%0d cpu_ack", k), cpu_ack, (k % 2) == 0);
            checkOutput($sformatf("alt%0d dbg_ack", k), dbg_ack, (k % 2) == 1);
        end
        checkOutput("alt cpu_inst", cpu_inst, romMem[0]);
        checkOutput("alt dbg_inst", dbg_inst, romMem[1]);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();

        // Randomized traffic against the reference model.
        doReset();
        servingPort = -1;
        lastGrant   = 1;
        latchedAddr = 32'h0;
        for (int p = 0; p < 2; p++) begin
            mReq[p] = 1'b0;
            mAddr[p] = 32'h0;
            expInst[p] = 32'h0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus(mReq[0], mAddr[0], mReq[1], mAddr[1]);
            for (int p = 0; p < 2; p++) begin
                expAck[p] = (servingPort == p);
                expErr[p] = expAck[p] && outOfRange(latchedAddr);
                if (expAck[p]) expInst[p] = expectedWord(latchedAddr);
                elig[p] = mReq[p] && (servingPort != p);
            end
            winner = -1;
            if (elig[0] && elig[1]) begin
`ifdef INST_ARB_ROUND_ROBIN_EN
                winner = (lastGrant == 0) ? 1 : 0;
`else
                winner = 0;
`endif
            end else if (elig[0]) begin
                winner = 0;
            end else if (elig[1]) begin
                winner = 1;
            end
            if (winner >= 0) begin
                latchedAddr = mAddr[winner];
                lastGrant   = winner;
            end
            servingPort = winner;
            tick();
            checkOutput("rand cpu_ack", cpu_ack, expAck[0]);
            checkOutput("rand cpu_err", cpu_err, expErr[0]);
            checkOutput("rand cpu_inst", cpu_inst, expInst[0]);
            checkOutput("rand dbg_ack", dbg_ack, expAck[1]);
            checkOutput("rand dbg_err", dbg_err, expErr[1]);
            checkOutput("rand dbg_inst", dbg_inst, expInst[1]);
            checkOutput("rand busy", busy, servingPort >= 0);
            checkOutput("rand rom_en", rom_en, (servingPort >= 0) && !outOfRange(latchedAddr));
            checkOutput("rand rom_addr", rom_addr, latchedAddr & 32'hFFFF_FFFC);
            checkOutput("rand cpu_stall", cpu_stall, mReq[0] && !expAck[0]);
            for (int p = 0; p < 2; p++) begin
                if (mReq[p]) begin
                    if (expAck[p]) begin
                        case ($urandom_range(0, 2))
                            0: mReq[p] = 1'b0;
                            1: mAddr[p] = randomAddr();
                            default: ;
                        endcase
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    mReq[p]  = 1'b1;
                    mAddr[p] = randomAddr();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
